// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared constants, FSM encoding and PC helper for the M0 fetch unit
package fetch_unit_pkg;

  localparam int ADDR_BUS = 32;
  localparam int INST_BUS = 32;

  localparam logic [INST_BUS-1:0] NOP_INST         = 32'h0000_0000;
  localparam logic [ADDR_BUS-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic ROM_ENABLE  = 1'b1;
  localparam logic ROM_DISABLE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  function automatic logic [ADDR_BUS-1:0] pc_advance(input logic [ADDR_BUS-1:0] pc,
                                                      input logic [ADDR_BUS-1:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// rtl/fetch_pc_gen.sv - PC register, pending-redirect latch and next-PC selection
module fetch_pc_gen
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                complete,
  input  logic                branch_accept,
  input  logic                in_hold,
  input  logic [ADDR_BUS-1:0] branch_addr,
  output logic [ADDR_BUS-1:0] pc
);

  logic                redirect_pending;
  logic [ADDR_BUS-1:0] redirect_addr;
  logic [ADDR_BUS-1:0] next_pc;

  always_comb begin
    next_pc = pc_advance(pc, PC_STEP);
    if (branch_accept) begin
      next_pc = branch_addr;
    end else if (redirect_pending) begin
      next_pc = redirect_addr;
    end
  end

  // A branch seen while the delay slot is still in flight is parked until that slot completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc               <= RESET_PC;
      redirect_pending <= 1'b0;
      redirect_addr    <= '0;
    end else if (complete) begin
      pc               <= next_pc;
      redirect_pending <= 1'b0;
    end else if (branch_accept) begin
      if (in_hold) begin
        pc <= branch_addr;
      end else begin
        redirect_pending <= 1'b1;
        redirect_addr    <= branch_addr;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - M0 IF stage: ROM request FSM, hold buffer and IF/ID register
// Optional FETCH_ALIGN_CHECK_EN: misaligned PCs deliver a NOP flagged on id_misalign.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [ADDR_BUS-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [ADDR_BUS-1:0] PC_STEP  = 32'd4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                branch_flag,
  input  logic [ADDR_BUS-1:0] branch_addr,
  output logic                rom_en,
  output logic [ADDR_BUS-1:0] rom_addr,
  input  logic                rom_ready,
  input  logic [INST_BUS-1:0] rom_data,
  output logic [ADDR_BUS-1:0] id_addr,
  output logic [INST_BUS-1:0] id_inst,
  output logic                id_valid
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                id_misalign
`endif
);

  fetch_state_t        state;
  fetch_state_t        next_state;
  logic [ADDR_BUS-1:0] pc;
  logic                complete;
  logic                branch_accept;
  logic                load_id_rom;
  logic                load_id_hold;
  logic                load_hold;
  logic                bubble;
  logic                misaligned;
  logic [INST_BUS-1:0] fetched_inst;
  logic [ADDR_BUS-1:0] hold_addr;
  logic [INST_BUS-1:0] hold_inst;

  assign branch_accept = branch_flag && id_valid && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
  logic hold_misalign;

  assign misaligned   = (pc[1:0] != 2'b00);
  assign rom_addr     = pc;
  assign fetched_inst = misaligned ? NOP_INST : rom_data;
`else
  assign misaligned   = 1'b0;
  assign rom_addr     = {pc[ADDR_BUS-1:2], 2'b00};
  assign fetched_inst = rom_data;
`endif

  fetch_pc_gen #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_gen (
    .clk           (clk),
    .rst           (rst),
    .complete      (complete),
    .branch_accept (branch_accept),
    .in_hold       (state == ST_HOLD),
    .branch_addr   (branch_addr),
    .pc            (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state   = state;
    rom_en       = ROM_DISABLE;
    complete     = 1'b0;
    load_id_rom  = 1'b0;
    load_id_hold = 1'b0;
    load_hold    = 1'b0;
    bubble       = 1'b0;
    case (state)
      ST_IDLE: begin
        next_state = ST_FETCH;
      end
      ST_FETCH: begin
        // A misaligned fetch never reaches the ROM; it retires on its own as a NOP.
        rom_en   = misaligned ? ROM_DISABLE : ROM_ENABLE;
        complete = misaligned || (rom_en && rom_ready);
        if (complete) begin
          if (stall) begin
            load_hold  = 1'b1;
            next_state = ST_HOLD;
          end else begin
            load_id_rom = 1'b1;
          end
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      ST_HOLD: begin
        if (!stall) begin
          load_id_hold = 1'b1;
          next_state   = ST_FETCH;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_addr   <= '0;
      id_inst   <= '0;
      id_valid  <= 1'b0;
      hold_addr <= '0;
      hold_inst <= '0;
    end else begin
      if (load_id_rom) begin
        id_addr  <= pc;
        id_inst  <= fetched_inst;
        id_valid <= 1'b1;
      end else if (load_id_hold) begin
        id_addr  <= hold_addr;
        id_inst  <= hold_inst;
        id_valid <= 1'b1;
      end else if (bubble) begin
        id_valid <= 1'b0;
      end
      if (load_hold) begin
        hold_addr <= pc;
        hold_inst <= fetched_inst;
      end
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      id_misalign   <= 1'b0;
      hold_misalign <= 1'b0;
    end else begin
      if (load_id_rom) begin
        id_misalign <= misaligned;
      end else if (load_id_hold) begin
        id_misalign <= hold_misalign;
      end
      if (load_hold) begin
        hold_misalign <= misaligned;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus randomized stream scoreboard for fetch_unit
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  typedef struct {
    logic        stall;
    logic        rdy;
    logic        br;
    logic [31:0] baddr;
    logic        e_rom_en;
    logic        chk_addr;
    logic [31:0] e_rom_addr;
    logic        e_valid;
    logic [31:0] e_id_addr;
    logic [31:0] e_id_inst;
    logic        e_mis;
  } vec_t;

`ifdef FETCH_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, branch_flag, rom_en, rom_ready, id_valid;
  logic [31:0] branch_addr, rom_addr, rom_data, id_addr, id_inst;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        id_misalign;
`endif

  int checks = 0;
  int errors = 0;

  vec_t        tbl[40];
  logic [31:0] addr_hist[4096];
  logic [31:0] tgt[4096];
  bit          taken[4096];
  int          k, quiet;
  bit          mdl_valid, hung;
  logic [31:0] mdl_addr, mdl_inst;

  always #5 clk = ~clk;

  // ROM word at byte address A holds A+1; garbage whenever it is not ready.
  assign rom_data = rom_ready ? (rom_addr + 32'd1) : 32'hDEAD_BEEF;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .branch_flag (branch_flag),
    .branch_addr (branch_addr),
    .rom_en      (rom_en),
    .rom_addr    (rom_addr),
    .rom_ready   (rom_ready),
    .rom_data    (rom_data),
    .id_addr     (id_addr),
    .id_inst     (id_inst),
    .id_valid    (id_valid)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .id_misalign (id_misalign)
`endif
  );

  function automatic vec_t mk(logic s, logic r, logic b, logic [31:0] ba, logic en, logic ca,
                              logic [31:0] ra, logic v, logic [31:0] ia, logic [31:0] ii, logic m);
    vec_t t;
    t.stall = s; t.rdy = r; t.br = b; t.baddr = ba;
    t.e_rom_en = en; t.chk_addr = ca; t.e_rom_addr = ra;
    t.e_valid = v; t.e_id_addr = ia; t.e_id_inst = ii; t.e_mis = m;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    stall = v.stall; rom_ready = v.rdy; branch_flag = v.br; branch_addr = v.baddr;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".rom_en"}, 32'(rom_en), 32'(v.e_rom_en));
    if (v.chk_addr) chk({tag, ".rom_addr"}, rom_addr, v.e_rom_addr);
    chk({tag, ".id_valid"}, 32'(id_valid), 32'(v.e_valid));
    chk({tag, ".id_addr"}, id_addr, v.e_id_addr);
    chk({tag, ".id_inst"}, id_inst, v.e_id_inst);
`ifdef FETCH_ALIGN_CHECK_EN
    chk({tag, ".id_misalign"}, 32'(id_misalign), 32'(v.e_mis));
`endif
  endtask

  // Address of the j-th delivered instruction: sequential, except two after an accepted branch.
  function automatic logic [31:0] stream_addr(input int j);
    if (j == 0) return RESET_PC_DEFAULT;
    if (j >= 2 && taken[j-2]) return tgt[j-2];
    return addr_hist[j-1] + 32'd4;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    if (ALN) return (a[1:0] != 2'b00) ? NOP_INST : a + 32'd1;
    return {a[31:2], 2'b00} + 32'd1;
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    return ALN ? a : {a[31:2], 2'b00};
  endfunction

  initial begin
    tbl[0]  = mk(0,1,0,0,            1,1,0,            0,0,0,0);
    tbl[1]  = mk(0,1,0,0,            1,1,4,            1,0,1,0);
    tbl[2]  = mk(0,1,0,0,            1,1,8,            1,4,5,0);
    tbl[3]  = mk(0,0,0,0,            1,1,8,            0,4,5,0);
    tbl[4]  = mk(0,0,0,0,            1,1,8,            0,4,5,0);
    tbl[5]  = mk(0,1,0,0,            1,1,12,           1,8,9,0);
    tbl[6]  = mk(1,1,0,0,            0,0,0,            1,8,9,0);
    tbl[7]  = mk(1,1,0,0,            0,0,0,            1,8,9,0);
    tbl[8]  = mk(1,1,0,0,            0,0,0,            1,8,9,0);
    tbl[9]  = mk(0,1,0,0,            1,1,16,           1,12,13,0);
    tbl[10] = mk(0,1,0,0,            1,1,20,           1,16,17,0);
    tbl[11] = mk(0,1,1,32'h100,      1,1,32'h100,      1,20,21,0);
    tbl[12] = mk(0,1,0,0,            1,1,32'h104,      1,32'h100,32'h101,0);
    tbl[13] = mk(0,0,1,32'h200,      1,1,32'h104,      0,32'h100,32'h101,0);
    tbl[14] = mk(0,0,0,0,            1,1,32'h104,      0,32'h100,32'h101,0);
    tbl[15] = mk(0,1,0,0,            1,1,32'h200,      1,32'h104,32'h105,0);
    tbl[16] = mk(0,1,0,0,            1,1,32'h204,      1,32'h200,32'h201,0);
    tbl[17] = mk(1,1,0,0,            0,0,0,            1,32'h200,32'h201,0);
    tbl[18] = mk(0,1,1,32'h300,      1,1,32'h300,      1,32'h204,32'h205,0);
    tbl[19] = mk(0,1,0,0,            1,1,32'h304,      1,32'h300,32'h301,0);
    tbl[20] = mk(0,1,1,32'hFFFF_FFF8,1,1,32'hFFFF_FFF8,1,32'h304,32'h305,0);
    tbl[21] = mk(0,1,0,0,            1,1,32'hFFFF_FFFC,1,32'hFFFF_FFF8,32'hFFFF_FFF9,0);
    tbl[22] = mk(0,1,0,0,            1,1,0,            1,32'hFFFF_FFFC,32'hFFFF_FFFD,0);
    tbl[23] = mk(0,1,0,0,            1,1,4,            1,0,1,0);
    tbl[24] = mk(1,0,0,0,            1,1,4,            1,0,1,0);
    tbl[25] = mk(0,1,0,0,            1,1,8,            1,4,5,0);
    tbl[26] = mk(1,0,1,32'h500,      1,1,8,            1,4,5,0);
    tbl[27] = mk(0,1,0,0,            1,1,12,           1,8,9,0);
    tbl[28] = mk(0,0,0,0,            1,1,12,           0,8,9,0);
    tbl[29] = mk(0,0,1,32'h600,      1,1,12,           0,8,9,0);
    tbl[30] = mk(0,1,0,0,            1,1,16,           1,12,13,0);
    tbl[31] = mk(0,1,1,32'h102,      !ALN,!ALN,32'h100,1,16,17,0);
    tbl[32] = mk(0,1,0,0,            !ALN,!ALN,32'h104,1,32'h102,ALN ? 32'h0 : 32'h101,ALN);
    tbl[33] = mk(0,1,1,32'h400,      1,1,32'h400,      1,32'h106,ALN ? 32'h0 : 32'h105,ALN);
    tbl[34] = mk(0,1,0,0,            1,1,32'h404,      1,32'h400,32'h401,0);
    tbl[35] = mk(0,1,1,32'h201,      !ALN,!ALN,32'h200,1,32'h404,32'h405,0);
    tbl[36] = mk(1,1,0,0,            0,0,0,            1,32'h404,32'h405,0);
    tbl[37] = mk(0,1,0,0,            !ALN,!ALN,32'h204,1,32'h201,ALN ? 32'h0 : 32'h201,ALN);
    tbl[38] = mk(0,1,1,32'h40,       1,1,32'h40,       1,32'h205,ALN ? 32'h0 : 32'h205,ALN);
    tbl[39] = mk(0,1,0,0,            1,1,32'h44,       1,32'h40,32'h41,0);

    rst = 1'b1; stall = 1'b0; branch_flag = 1'b0; branch_addr = '0; rom_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset.rom_en", 32'(rom_en), 32'd0);
    chk("reset.id_valid", 32'(id_valid), 32'd0);
    chk("reset.id_addr", id_addr, 32'd0);
    chk("reset.id_inst", id_inst, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset while a request is outstanding, with rom_ready arriving in the same cycle.
    run_vec(mk(0,0,0,0, 1,1,32'h44, 0,32'h40,32'h41,0), "rstseq0");
    rst = 1'b1;
    run_vec(mk(0,1,0,0, 0,0,0, 0,0,0,0), "rstseq1");
    rst = 1'b0;
    run_vec(mk(0,1,0,0, 1,1,0, 0,0,0,0), "rstseq2");
    run_vec(mk(0,1,0,0, 1,1,4, 1,0,1,0), "rstseq3");

    rst = 1'b1; stall = 1'b0; rom_ready = 1'b0; branch_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    k = -1; quiet = 0; hung = 1'b0;
    mdl_valid = 1'b0; mdl_addr = '0; mdl_inst = '0;
    for (int i = 0; i < 4096; i++) taken[i] = 1'b0;

    for (int c = 0; c < 3000 && !hung && k < 4000; c++) begin
      stall       = ($urandom_range(0, 3) == 0);
      rom_ready   = ($urandom_range(0, 2) != 0);
      branch_flag = ($urandom_range(0, 4) == 0);
      branch_addr = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : ($urandom_range(0, 1023) << 2);
      if (branch_flag && mdl_valid && !stall && k >= 0) begin
        taken[k] = 1'b1;
        tgt[k]   = branch_addr;
      end
      @(posedge clk);
      @(negedge clk);
      if (stall) begin
        chk("rnd.stall_valid", 32'(id_valid), 32'(mdl_valid));
        chk("rnd.stall_addr", id_addr, mdl_addr);
        chk("rnd.stall_inst", id_inst, mdl_inst);
        quiet++;
      end else if (id_valid) begin
        k++;
        addr_hist[k] = stream_addr(k);
        mdl_valid = 1'b1;
        mdl_addr  = addr_hist[k];
        mdl_inst  = exp_inst(addr_hist[k]);
        chk("rnd.id_addr", id_addr, mdl_addr);
        chk("rnd.id_inst", id_inst, mdl_inst);
        quiet = 0;
      end else begin
        mdl_valid = 1'b0;
        chk("rnd.bubble_addr", id_addr, mdl_addr);
        chk("rnd.bubble_inst", id_inst, mdl_inst);
        quiet++;
      end
      if (rom_en) chk("rnd.rom_addr", rom_addr, fetch_word(stream_addr(k + 1)));
      if (quiet > 60) begin
        checks++;
        errors++;
        $display("FAIL rnd.progress: no delivery for %0d cycles, required at most 60", quiet);
        hung = 1'b1;
      end
    end
    chk("rnd.deliveries", 32'(k > 500), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
